// File: rtl/rr_arbiter16_lowgrant.sv
// Round-robin arbiter for 16 active-low requesters with an active-low one-hot grant,
// a binary grant index, and a programmable per-grant hold limit.
module rr_arbiter16_lowgrant #(
    parameter int unsigned MAXHOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nreq,
    output logic [15:0] ngnt,
    output logic [3:0]  gidx,
    output logic        gvalid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAXHOLD);

    state_e     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gidx_q, gidx_d;

    logic       found;
    logic [3:0] winner;
    logic [3:0] scan_idx;

    // Scan ptr+1 .. ptr+16 (mod 16), so the last holder is considered last.
    always_comb begin
        found    = 1'b0;
        winner   = ptr_q;
        scan_idx = ptr_q;
        for (int i = 1; i <= 16; i++) begin
            scan_idx = ptr_q + 4'(i);
            if (!found && !nreq[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gidx_d  = gidx_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d  = winner;
                    cnt_d   = 8'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (nreq[gidx_q] || (cnt_q == HOLD_LIMIT)) begin
                    ptr_d   = gidx_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 4'd15;
            cnt_q   <= 8'd0;
            gidx_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gidx_q  <= gidx_d;
        end
    end

    // Outputs come from registered state only; nreq never reaches them combinationally.
    always_comb begin
        gvalid = (state_q == GRANT);
        gidx   = gidx_q;
        ngnt   = 16'hFFFF;
        if (state_q == GRANT) begin
            ngnt = ~(16'h0001 << gidx_q);
        end
    end

endmodule

// File: tb/tb_rr_arbiter16_lowgrant.sv
// Self-checking bench: three arbiters (hold limits 1, 4, 8) share one stimulus stream
// and are compared every cycle against a behavioural round-robin model.
module tb_rr_arbiter16_lowgrant;

    logic        clk;
    logic        rst;
    logic [15:0] nreq;

    logic [15:0] ngnt_o   [3];
    logic [3:0]  gidx_o   [3];
    logic        gvalid_o [3];

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state per instance.
    int lim      [3] = '{1, 4, 8};
    int m_busy   [3];
    int m_owner  [3];
    int m_last   [3];
    int m_held   [3];

    rr_arbiter16_lowgrant #(.MAXHOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .nreq(nreq),
        .ngnt(ngnt_o[0]), .gidx(gidx_o[0]), .gvalid(gvalid_o[0])
    );
    rr_arbiter16_lowgrant #(.MAXHOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .nreq(nreq),
        .ngnt(ngnt_o[1]), .gidx(gidx_o[1]), .gvalid(gvalid_o[1])
    );
    rr_arbiter16_lowgrant #(.MAXHOLD(8)) u_dut8 (
        .clk(clk), .rst(rst), .nreq(nreq),
        .ngnt(ngnt_o[2]), .gidx(gidx_o[2]), .gvalid(gvalid_o[2])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one sampled edge using the rules of the arbiter.
    task automatic model_edge(input logic [15:0] n, input logic r);
        for (int h = 0; h < 3; h++) begin
            if (r) begin
                m_busy[h]  = 0;
                m_last[h]  = 15;
                m_held[h]  = 0;
                m_owner[h] = 0;
            end else if (m_busy[h] == 0) begin
                for (int k = 1; k <= 16; k++) begin
                    int c;
                    c = (m_last[h] + k) % 16;
                    if (m_busy[h] == 0 && n[c] == 1'b0) begin
                        m_busy[h]  = 1;
                        m_owner[h] = c;
                        m_held[h]  = 1;
                    end
                end
            end else if (n[m_owner[h]] == 1'b1 || m_held[h] == lim[h]) begin
                m_busy[h] = 0;
                m_last[h] = m_owner[h];
            end else begin
                m_held[h]++;
            end
        end
    endtask

    task automatic check_all();
        for (int h = 0; h < 3; h++) begin
            logic [15:0] exp_ngnt;
            exp_ngnt = 16'hFFFF;
            if (m_busy[h] != 0) exp_ngnt[m_owner[h]] = 1'b0;
            check($sformatf("ngnt[h%0d]", lim[h]), ngnt_o[h], exp_ngnt);
            check($sformatf("gidx[h%0d]", lim[h]), 16'(gidx_o[h]), 16'(m_owner[h]));
            check($sformatf("gvalid[h%0d]", lim[h]), 16'(gvalid_o[h]), 16'(m_busy[h] != 0));
        end
    endtask

    task automatic step(input logic [15:0] n, input logic r);
        nreq = n;
        rst  = r;
        @(posedge clk);
        model_edge(n, r);
        #1;
        check_all();
    endtask

    initial begin
        clk  = 1'b0;
        rst  = 1'b1;
        nreq = 16'hFFFF;
        for (int h = 0; h < 3; h++) begin
            m_busy[h] = 0; m_owner[h] = 0; m_last[h] = 15; m_held[h] = 0;
        end

        // Reset held two cycles with every request asserted.
        step(16'h0000, 1'b1);
        step(16'h0000, 1'b1);
        check("reset_ngnt_const", ngnt_o[2], 16'hFFFF);
        check("reset_gidx_const", 16'(gidx_o[2]), 16'h0000);
        step(16'h0000, 1'b0);
        check("first_grant_const", ngnt_o[2], 16'hFFFE);

        // Single request to 5, released early.
        step(16'hFFFF, 1'b1);
        step(16'hFFDF, 1'b0);
        check("req5_ngnt_const", ngnt_o[2], 16'hFFDF);
        check("req5_gidx_const", 16'(gidx_o[2]), 16'd5);
        step(16'hFFDF, 1'b0);
        step(16'hFFDF, 1'b0);
        step(16'hFFFF, 1'b0);
        check("req5_release_const", ngnt_o[2], 16'hFFFF);
        step(16'hFFFF, 1'b0);

        // Full rotation: every requester busy, 16 grants plus slack.
        step(16'hFFFF, 1'b1);
        for (int i = 0; i < 190; i++) step(16'h0000, 1'b0);

        // Wrap priority: grant 14, release, then bits 3 and 15 request.
        step(16'hFFFF, 1'b1);
        step(16'hBFFF, 1'b0);
        step(16'hFFFF, 1'b0);
        step(16'hFFFF, 1'b0);
        step(16'h7FF7, 1'b0);
        check("wrap_first_const", ngnt_o[2], 16'h7FFF);
        for (int i = 0; i < 8; i++) step(16'h7FF7, 1'b0);
        step(16'hFFF7, 1'b0);
        check("wrap_second_const", ngnt_o[2], 16'hFFF7);
        for (int i = 0; i < 4; i++) step(16'hFFFF, 1'b0);

        // Sole requester hitting the hold limit repeatedly.
        for (int i = 0; i < 30; i++) step(16'hF7FF, 1'b0);
        step(16'hFFFF, 1'b0);

        // Reset in the 2nd cycle of a grant to 9.
        step(16'hFFFF, 1'b1);
        step(16'hFDFF, 1'b0);
        step(16'hFDFF, 1'b0);
        step(16'hFDFF, 1'b1);
        check("midgrant_rst_const", ngnt_o[2], 16'hFFFF);
        step(16'hFDFF, 1'b0);
        check("regrant9_const", ngnt_o[2], 16'hFDFF);
        step(16'hFFFF, 1'b0);
        step(16'hFFFF, 1'b0);

        // Randomized traffic: mix of idle, sparse and dense request patterns.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] n;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      n = 16'hFFFF;
            else if (sel < 5)  n = ~(16'h0001 << $urandom_range(0, 15)) & ~(16'h0001 << $urandom_range(0, 15));
            else if (sel < 8)  n = 16'($urandom) | 16'($urandom);
            else               n = 16'($urandom);
            step(n, ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
